otter_mem_arbiter: RTL and testbench

Arbitrates a single-ported, byte-addressed OTTER memory between three requesters: instruction fetch (IF), load/store data (D) and a debug/DMA port (DBG). It issues at most one memory access per cycle and routes each read response back to its originator exactly one cycle after the grant. Anti-starvation counters guarantee forward progress for IF and DBG under sustained data traffic. It sits between the MCU datapath and the memory/MMIO block.

---
 rtl/otter_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_otter_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mem_arbiter.sv
// Three-way arbiter (IF / D / DBG) for the single-ported OTTER memory: grant is combinational, read data returns one cycle later.
// Backpressure: MEM_BUSY blocks every grant; requesters hold REQ until GNT, and starving IF/DBG get promoted after STARVE_LIMIT cycles.
module otter_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_GNT,
  output logic        IF_RVALID,
  output logic [31:0] IF_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [1:0]  D_SIZE,
  input  logic        D_SIGN,
  output logic        D_GNT,
  output logic        D_RVALID,
  output logic [31:0] D_RDATA,
  input  logic        DBG_REQ,
  input  logic        DBG_WE,
  input  logic [31:0] DBG_ADDR,
  input  logic [31:0] DBG_WDATA,
  input  logic [1:0]  DBG_SIZE,
  input  logic        DBG_SIGN,
  output logic        DBG_GNT,
  output logic        DBG_RVALID,
  output logic [31:0] DBG_RDATA,
  input  logic        MEM_BUSY,
  output logic        MEM_RE,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_DIN,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_D, SRC_DBG} src_t;

  src_t             win;
  src_t             owner;
  src_t             owner_nxt;
  logic [CNT_W-1:0] if_cnt;
  logic [CNT_W-1:0] dbg_cnt;
  logic [CNT_W-1:0] if_cnt_nxt;
  logic [CNT_W-1:0] dbg_cnt_nxt;

  // Starved requesters outrank D; otherwise D > DBG > IF.
  always_comb begin
    win = SRC_NONE;
    if (RESET_N && !MEM_BUSY) begin
      if (IF_REQ && if_cnt == LIMIT)        win = SRC_IF;
      else if (DBG_REQ && dbg_cnt == LIMIT) win = SRC_DBG;
      else if (D_REQ)                       win = SRC_D;
      else if (DBG_REQ)                     win = SRC_DBG;
      else if (IF_REQ)                      win = SRC_IF;
    end
  end

  assign IF_GNT  = (win == SRC_IF);
  assign D_GNT   = (win == SRC_D);
  assign DBG_GNT = (win == SRC_DBG);

  always_comb begin
    MEM_RE   = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = 32'h0;
    MEM_DIN  = 32'h0;
    MEM_SIZE = 2'b00;
    MEM_SIGN = 1'b0;
    case (win)
      SRC_IF: begin
        MEM_RE   = 1'b1;
        MEM_ADDR = IF_ADDR;
        MEM_SIZE = 2'b10;
      end
      SRC_D: begin
        MEM_RE   = !D_WE;
        MEM_WE   = D_WE;
        MEM_ADDR = D_ADDR;
        MEM_DIN  = D_WDATA;
        MEM_SIZE = D_SIZE;
        MEM_SIGN = D_SIGN;
      end
      SRC_DBG: begin
        MEM_RE   = !DBG_WE;
        MEM_WE   = DBG_WE;
        MEM_ADDR = DBG_ADDR;
        MEM_DIN  = DBG_WDATA;
        MEM_SIZE = DBG_SIZE;
        MEM_SIGN = DBG_SIGN;
      end
      default: ;
    endcase
  end

  // Only reads claim the response slot; busy cycles still age waiting requesters.
  always_comb begin
    owner_nxt   = MEM_RE ? win : SRC_NONE;
    if_cnt_nxt  = if_cnt;
    dbg_cnt_nxt = dbg_cnt;
    if (!IF_REQ || IF_GNT)    if_cnt_nxt = '0;
    else if (if_cnt != LIMIT) if_cnt_nxt = if_cnt + 1'b1;
    if (!DBG_REQ || DBG_GNT)   dbg_cnt_nxt = '0;
    else if (dbg_cnt != LIMIT) dbg_cnt_nxt = dbg_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      owner   <= SRC_NONE;
      if_cnt  <= '0;
      dbg_cnt <= '0;
    end else begin
      owner   <= owner_nxt;
      if_cnt  <= if_cnt_nxt;
      dbg_cnt <= dbg_cnt_nxt;
    end
  end

  assign IF_RVALID  = (owner == SRC_IF);
  assign D_RVALID   = (owner == SRC_D);
  assign DBG_RVALID = (owner == SRC_DBG);
  assign IF_RDATA   = IF_RVALID  ? MEM_DOUT : 32'h0;
  assign D_RDATA    = D_RVALID   ? MEM_DOUT : 32'h0;
  assign DBG_RDATA  = DBG_RVALID ? MEM_DOUT : 32'h0;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: table of per-cycle vectors plus hand sequences for reset, pipelining, starvation and busy.
module tb_otter_mem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        IF_REQ, D_REQ, D_WE, D_SIGN, DBG_REQ, DBG_WE, DBG_SIGN, MEM_BUSY;
  logic [31:0] IF_ADDR, D_ADDR, D_WDATA, DBG_ADDR, DBG_WDATA, MEM_DOUT;
  logic [1:0]  D_SIZE, DBG_SIZE;
  logic        IF_GNT, IF_RVALID, D_GNT, D_RVALID, DBG_GNT, DBG_RVALID;
  logic [31:0] IF_RDATA, D_RDATA, DBG_RDATA;
  logic        MEM_RE, MEM_WE, MEM_SIGN;
  logic [31:0] MEM_ADDR, MEM_DIN;
  logic [1:0]  MEM_SIZE;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  otter_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_SIZE(D_SIZE), .D_SIGN(D_SIGN),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA), .DBG_SIZE(DBG_SIZE),
    .DBG_SIGN(DBG_SIGN), .DBG_GNT(DBG_GNT), .DBG_RVALID(DBG_RVALID), .DBG_RDATA(DBG_RDATA),
    .MEM_BUSY(MEM_BUSY), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT(MEM_DOUT)
  );

  // gnt/rv encodings are {IF, D, DBG}
  typedef struct {
    logic        if_req;
    logic        d_req;
    logic        d_we;
    logic        dbg_req;
    logic        dbg_we;
    logic        busy;
    logic [31:0] dout;
    logic [2:0]  exp_gnt;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [2:0]  exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] gnts();
    return {IF_GNT, D_GNT, DBG_GNT};
  endfunction

  function automatic logic [2:0] rvs();
    return {IF_RVALID, D_RVALID, DBG_RVALID};
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_reqs();
    IF_REQ = 1'b0; D_REQ = 1'b0; DBG_REQ = 1'b0; MEM_BUSY = 1'b0;
  endtask

  initial begin
    logic [1:0]  exp_size;
    logic        exp_sign;
    logic [31:0] exp_din;
    logic [2:0]  stv_exp[7];

    vecs[0]  = '{H,L,L,L,L,L,32'h0,  3'b100,H,L,32'h100,  3'b000,32'h0};
    vecs[1]  = '{L,L,L,L,L,L,32'h13, 3'b000,L,L,32'h0,    3'b100,32'h13};
    vecs[2]  = '{H,H,H,L,L,L,32'h0,  3'b010,L,H,32'h2000, 3'b000,32'h0};
    vecs[3]  = '{H,L,L,L,L,L,32'h55, 3'b100,H,L,32'h100,  3'b000,32'h0};
    vecs[4]  = '{H,H,L,H,L,L,32'hAA, 3'b010,H,L,32'h2000, 3'b100,32'hAA};
    vecs[5]  = '{H,L,L,H,L,L,32'h11, 3'b001,H,L,32'h3000, 3'b010,32'h11};
    vecs[6]  = '{H,L,L,L,L,L,32'h22, 3'b100,H,L,32'h100,  3'b001,32'h22};
    vecs[7]  = '{L,L,L,L,L,L,32'h33, 3'b000,L,L,32'h0,    3'b100,32'h33};
    vecs[8]  = '{L,L,L,H,H,L,32'h0,  3'b001,L,H,32'h3000, 3'b000,32'h0};
    vecs[9]  = '{H,H,L,L,L,H,32'h0,  3'b000,L,L,32'h0,    3'b000,32'h0};
    vecs[10] = '{L,L,L,L,L,L,32'h0,  3'b000,L,L,32'h0,    3'b000,32'h0};
    vecs[11] = '{L,H,L,L,L,L,32'h0,  3'b010,H,L,32'h2000, 3'b000,32'h0};
    vecs[12] = '{L,L,L,L,L,H,32'h77, 3'b000,L,L,32'h0,    3'b010,32'h77};
    vecs[13] = '{L,L,L,L,L,L,32'h0,  3'b000,L,L,32'h0,    3'b000,32'h0};

    // IF starved at the 5th cycle, then DBG (saturated), then D again
    stv_exp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010};

    IF_ADDR = 32'h100; D_ADDR = 32'h2000; D_WDATA = 32'hDEADBEEF; D_SIZE = 2'b00; D_SIGN = 1'b1;
    DBG_ADDR = 32'h3000; DBG_WDATA = 32'h12345678; DBG_SIZE = 2'b01; DBG_SIGN = 1'b0;
    D_WE = 1'b0; DBG_WE = 1'b0; MEM_DOUT = 32'h0; MEM_BUSY = 1'b0;

    // Reset held with every requester active
    RESET_N = 1'b0; IF_REQ = 1'b1; D_REQ = 1'b1; DBG_REQ = 1'b1;
    @(negedge CLK);
    chk("rst_gnt", 32'(gnts()), 32'h0);
    chk("rst_rvalid", 32'(rvs()), 32'h0);
    chk("rst_re_we", {30'h0, MEM_RE, MEM_WE}, 32'h0);
    next_cycle();
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("rst_release_gnt", 32'(gnts()), 32'h2);
    next_cycle();
    idle_reqs(); MEM_DOUT = 32'h99;
    @(negedge CLK);
    chk("rst_first_rv", 32'(rvs()), 32'h2);
    chk("rst_first_rdata", D_RDATA, 32'h99);
    next_cycle();

    for (int i = 0; i < 14; i++) begin
      IF_REQ = vecs[i].if_req; D_REQ = vecs[i].d_req; D_WE = vecs[i].d_we;
      DBG_REQ = vecs[i].dbg_req; DBG_WE = vecs[i].dbg_we; MEM_BUSY = vecs[i].busy;
      MEM_DOUT = vecs[i].dout;
      case (vecs[i].exp_gnt)
        3'b100:  begin exp_size = 2'b10;    exp_sign = 1'b0;     exp_din = 32'h0;     end
        3'b010:  begin exp_size = D_SIZE;   exp_sign = D_SIGN;   exp_din = D_WDATA;   end
        3'b001:  begin exp_size = DBG_SIZE; exp_sign = DBG_SIGN; exp_din = DBG_WDATA; end
        default: begin exp_size = 2'b00;    exp_sign = 1'b0;     exp_din = 32'h0;     end
      endcase
      @(negedge CLK);
      chk($sformatf("v%0d_gnt", i), 32'(gnts()), 32'(vecs[i].exp_gnt));
      chk($sformatf("v%0d_re_we", i), {30'h0, MEM_RE, MEM_WE}, {30'h0, vecs[i].exp_re, vecs[i].exp_we});
      chk($sformatf("v%0d_addr", i), MEM_ADDR, vecs[i].exp_addr);
      chk($sformatf("v%0d_din", i), MEM_DIN, exp_din);
      chk($sformatf("v%0d_size_sign", i), {29'h0, MEM_SIZE, MEM_SIGN}, {29'h0, exp_size, exp_sign});
      chk($sformatf("v%0d_rv", i), 32'(rvs()), 32'(vecs[i].exp_rv));
      chk($sformatf("v%0d_if_rdata", i), IF_RDATA, vecs[i].exp_rv[2] ? vecs[i].exp_rdata : 32'h0);
      chk($sformatf("v%0d_d_rdata", i), D_RDATA, vecs[i].exp_rv[1] ? vecs[i].exp_rdata : 32'h0);
      chk($sformatf("v%0d_dbg_rdata", i), DBG_RDATA, vecs[i].exp_rv[0] ? vecs[i].exp_rdata : 32'h0);
      next_cycle();
    end

    // Back-to-back reads from three different requesters
    idle_reqs(); D_WE = 1'b0; DBG_WE = 1'b0;
    D_REQ = 1'b1; D_ADDR = 32'h10;
    @(negedge CLK);
    chk("pipe_d_gnt", {D_GNT, MEM_ADDR[30:0]}, {1'b1, 31'h10});
    next_cycle();
    D_REQ = 1'b0; DBG_REQ = 1'b1; DBG_ADDR = 32'h20; MEM_DOUT = 32'hD0;
    @(negedge CLK);
    chk("pipe_dbg_gnt", {DBG_GNT, MEM_ADDR[30:0]}, {1'b1, 31'h20});
    chk("pipe_d_rv", {29'h0, rvs()}, 32'h2);
    chk("pipe_d_rdata", D_RDATA, 32'hD0);
    next_cycle();
    DBG_REQ = 1'b0; IF_REQ = 1'b1; IF_ADDR = 32'h30; MEM_DOUT = 32'hB0;
    @(negedge CLK);
    chk("pipe_if_gnt", {IF_GNT, MEM_ADDR[30:0]}, {1'b1, 31'h30});
    chk("pipe_dbg_rv", {29'h0, rvs()}, 32'h1);
    chk("pipe_dbg_rdata", DBG_RDATA, 32'hB0);
    next_cycle();
    IF_REQ = 1'b0; MEM_DOUT = 32'hF0;
    @(negedge CLK);
    chk("pipe_if_rv", {29'h0, rvs()}, 32'h4);
    chk("pipe_if_rdata", IF_RDATA, 32'hF0);
    next_cycle();

    // Sustained D traffic with IF and DBG waiting
    idle_reqs();
    next_cycle();
    D_REQ = 1'b1; IF_REQ = 1'b1; DBG_REQ = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      chk($sformatf("starve_c%0d_gnt", c), 32'(gnts()), 32'(stv_exp[c]));
      next_cycle();
    end

    // Busy cycles age the waiting fetch
    idle_reqs();
    next_cycle();
    IF_REQ = 1'b1; D_REQ = 1'b1; MEM_BUSY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("busy_c%0d_gnt", c), {28'h0, gnts(), MEM_RE | MEM_WE}, 32'h0);
      next_cycle();
    end
    MEM_BUSY = 1'b0;
    @(negedge CLK);
    chk("busy_after_d_gnt", 32'(gnts()), 32'h2);
    next_cycle();
    @(negedge CLK);
    chk("busy_after_if_gnt", 32'(gnts()), 32'h4);
    next_cycle();

    // Reset while a read response is pending
    idle_reqs();
    next_cycle();
    IF_REQ = 1'b1;
    @(negedge CLK);
    chk("rstmid_if_gnt", 32'(gnts()), 32'h4);
    next_cycle();
    IF_REQ = 1'b0; MEM_DOUT = 32'hCAFE;
    #1 RESET_N = 1'b0;
    @(negedge CLK);
    chk("rstmid_rv_during", 32'(rvs()), 32'h0);
    chk("rstmid_rdata_during", IF_RDATA, 32'h0);
    next_cycle();
    RESET_N = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk($sformatf("rstmid_rv_after%0d", c), 32'(rvs()), 32'h0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
